uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Serial transmitter paired with the board's UART_RX input; carries bytes from the core out to the host as 8N1 or 8N2 frames.
- A 2^FIFO_AW-entry byte FIFO decouples CPU I/O-port writes from the serial bit rate.
- Sits beside the CPU I/O decode, clocked by the CPU clock domain; the tx output drives the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, 35, clock cycles per serial bit (35 at 4 MHz gives ≈115200 baud); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  8  byte to enqueue.
- wr  input  1  enqueue strobe, one byte per cycle where high.
- full  output  1  FIFO holds 2^FIFO_AW bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  FIFO_AW+1  number of bytes currently queued (excludes the byte being shifted).
- busy  output  1  high while a frame is on the line (any state except IDLE).
- overflow  output  1  one-cycle pulse when a write is dropped.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (async, while high): tx=1, busy=0, overflow=0, full=0, empty=1, count=0, FIFO pointers cleared, state=IDLE, bit and baud counters cleared. Asserting reset mid-frame aborts it: tx goes high immediately and queued bytes are discarded.
- FIFO write: on each edge with wr=1 and not full, din is stored and count increments.
- FIFO write when full: if full and no pop occurs in the same cycle, the byte is dropped and overflow=1 for exactly that next cycle. If full and a pop occurs in the same cycle, the write is accepted and count stays unchanged.
- FIFO read: a pop happens only on IDLE->START or STOP->START transitions. Pop with simultaneous accepted write leaves count unchanged.
- Counts: full = (count == 2^FIFO_AW); empty = (count == 0). Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1.
  - If the FIFO is non-empty, pop the head byte into the shift register, go to START, and clear the baud counter.
  - Latency: wr captured at edge N into an empty FIFO with IDLE → pop at edge N+1 → tx=0 after edge N+1, i.e. visible on the cycle after the write cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = shift[bit index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end of the stop period:
  - FIFO non-empty → pop and go to START on the same edge (no idle gap; back-to-back frames are exactly (10 or 11)*CLKS_PER_BIT cycles apart).
  - FIFO empty → go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; it must be wide enough for CLKS_PER_BIT-1.
- Registered tx: tx is driven from a register, with no combinational path from din or wr.
- busy: high from the START entry edge through the last stop cycle; low in IDLE.
- Input isolation: din and wr changes during a frame never affect the byte being shifted.

Test Plan:
- Reset, then single byte. CLKS_PER_BIT=4, write 0x55 once → tx is low starting the cycle after wr, then pattern 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles. busy is high for 40 cycles, then tx=1, busy=0, empty=1.
- Back-to-back frames. Write 0xA3 then 0x0F on consecutive cycles → two frames with no gap: 0,1,1,0,0,0,1,0,1,1 then 0,1,1,1,1,0,0,0,0,1. count goes 1→1→0 (the first byte pops at the same edge the second is written). Total line activity is 80 cycles.
- Overflow. Hold the transmitter in its first frame and write 18 bytes 0x00..0x11 on consecutive cycles → 0x00 is popped, 0x01..0x10 are queued (full=1, count=16), 0x11 is dropped with a single overflow pulse. The received sequence is 0x00..0x10.
- Full with simultaneous pop. With the FIFO full, write 0xEE on exactly the edge STOP->START pops → the write is accepted, count stays 16, overflow stays 0, and 0xEE is transmitted last.
- Reset mid-frame. Assert reset during data bit 3 of 0x00 with 5 bytes queued → tx=1 immediately (asynchronously), count=0, empty=1, busy=0. After release with no writes, tx stays high for 100 cycles.
- Two stop bits. STOP_BITS=2, CLKS_PER_BIT=3, write 0xFF, 0x00 → the first frame's high stop period lasts 6 cycles, and the second start bit begins exactly 33 cycles after the first.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1/8N2 UART transmitter

module uart_tx_fifo_queue #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        pop,
  output logic [7:0]  head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          accept;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a write.
  assign accept = wr && (!full || pop);
  assign head   = mem[rptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= wr && full && !pop;
    end
  end
endmodule

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 35,
  parameter int FIFO_AW      = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         din,
  input  logic               wr,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count,
  output logic               busy,
  output logic               overflow,
  output logic               tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          pop;
  logic [7:0]    head;
  logic          baud_last;

  uart_tx_fifo_queue #(.AW(FIFO_AW)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .wr       (wr),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  assign busy      = (state != IDLE);
  assign baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = START;
          baud_n  = '0;
        end
      end
      START: begin
        if (baud_last) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        // bit_idx counts stop bits here; the next frame starts without an idle gap.
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_n = '0;
            if (!empty) begin
              pop     = 1'b1;
              shift_n = head;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[bit_n];
      default: tx_n = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed scoreboard bench for uart_tx_fifo

module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset, wr, rst2, wr2;
  logic [7:0] din, din2;
  logic       full, empty, busy, overflow, tx;
  logic       full2, empty2, busy2, overflow2, tx2;
  logic [4:0] count, count2;

  int         n_checks = 0;
  int         n_fails = 0;
  logic [7:0] sb [$];
  int         rx_frames = 0;
  logic       rx_active = 1'b0;
  int         rx_k = 0;
  logic [9:0] rx_bits = '1;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .din(din), .wr(wr), .full(full), .empty(empty),
    .count(count), .busy(busy), .overflow(overflow), .tx(tx)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(3), .FIFO_AW(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(rst2), .din(din2), .wr(wr2), .full(full2), .empty(empty2),
    .count(count2), .busy(busy2), .overflow(overflow2), .tx(tx2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    step();
    wr  = 1'b0;
  endtask

  function automatic logic exp2(input int k);
    int f, j, b;
    logic [7:0] data;
    if (k >= 66) return 1'b1;
    f = k / 33;
    j = k % 33;
    b = j / 3;
    data = (f == 0) ? 8'hFF : 8'h00;
    if (b == 0) return 1'b0;
    if (b <= 8) return data[b-1];
    return 1'b1;
  endfunction

  // Receiver: checks every line cycle of each frame against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active && tx === 1'b0) begin
        rx_active = 1'b1;
        rx_k = 0;
        chk("rx_start_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) rx_bits = {1'b1, sb.pop_front(), 1'b0};
        else rx_bits = '1;
      end
      if (rx_active) begin
        chk("rx_line", 32'(tx), 32'(rx_bits[4'(rx_k / CPB)]));
        rx_k++;
        if (rx_k == 10 * CPB) begin
          rx_active = 1'b0;
          rx_frames++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, lows;
    reset = 1'b1; rst2 = 1'b1;
    wr = 1'b0; din = '0; wr2 = 1'b0; din2 = '0;
    repeat (3) step();
    reset = 1'b0; rst2 = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // single byte
    sb.push_back(8'h55);
    write_byte(8'h55);
    chk("t1_count_after_wr", 32'(count), 32'd1);
    chk("t1_tx_idle_on_wr_cycle", 32'(tx), 32'd1);
    step();
    chk("t1_tx_start", 32'(tx), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_empty_after_pop", 32'(empty), 32'd1);
    n = 0;
    while (busy && n < 200) begin n++; step(); end
    chk("t1_busy_cycles", 32'(n), 32'd40);
    chk("t1_tx_end", 32'(tx), 32'd1);
    chk("t1_empty_end", 32'(empty), 32'd1);

    // back-to-back frames
    sb.push_back(8'hA3);
    sb.push_back(8'h0F);
    write_byte(8'hA3);
    chk("t2_count_a", 32'(count), 32'd1);
    write_byte(8'h0F);
    chk("t2_count_b", 32'(count), 32'd1);
    n = 0;
    while (busy && n < 300) begin n++; step(); end
    chk("t2_busy_cycles", 32'(n), 32'd80);
    chk("t2_count_end", 32'(count), 32'd0);
    step();

    // overflow
    for (int i = 0; i < 18; i++) begin
      if (i <= 16) sb.push_back(8'(i));
      write_byte(8'(i));
      if (i == 16) begin
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count16", 32'(count), 32'd16);
        chk("t3_no_overflow_yet", 32'(overflow), 32'd0);
      end
    end
    chk("t3_overflow_pulse", 32'(overflow), 32'd1);
    chk("t3_count_after_drop", 32'(count), 32'd16);
    step();
    chk("t3_overflow_cleared", 32'(overflow), 32'd0);

    // full with simultaneous pop at STOP->START
    repeat (22) step();
    chk("t4_full_before", 32'(full), 32'd1);
    chk("t4_busy_before", 32'(busy), 32'd1);
    sb.push_back(8'hEE);
    write_byte(8'hEE);
    chk("t4_count_kept", 32'(count), 32'd16);
    chk("t4_overflow_zero", 32'(overflow), 32'd0);
    step();
    chk("t4_overflow_zero_next", 32'(overflow), 32'd0);
    n = 0;
    while ((busy || !empty) && n < 3000) begin n++; step(); end
    chk("t4_drain_in_time", 32'(n < 3000), 32'd1);
    chk("t4_scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("t4_frames_received", 32'(rx_frames), 32'd21);

    // reset mid-frame
    for (int i = 0; i < 6; i++) begin
      sb.push_back(8'(i * 17));
      write_byte(8'(i * 17));
    end
    repeat (13) step();
    chk("t5_in_bit3", 32'(tx), 32'd0);
    chk("t5_count5", 32'(count), 32'd5);
    reset = 1'b1;
    #1;
    chk("t5_async_tx", 32'(tx), 32'd1);
    chk("t5_async_count", 32'(count), 32'd0);
    chk("t5_async_empty", 32'(empty), 32'd1);
    chk("t5_async_busy", 32'(busy), 32'd0);
    sb.delete();
    step();
    step();
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1) lows++;
      step();
    end
    chk("t5_idle_after_reset", 32'(lows), 32'd0);
    chk("t5_count_after_reset", 32'(count), 32'd0);

    // two stop bits on the second instance
    wr2 = 1'b1; din2 = 8'hFF;
    step();
    chk("t6_tx_idle_on_wr", 32'(tx2), 32'd1);
    din2 = 8'h00;
    step();
    wr2 = 1'b0;
    for (int k = 0; k < 70; k++) begin
      chk($sformatf("t6_tx_k%0d", k), 32'(tx2), 32'(exp2(k)));
      if (k == 65) chk("t6_busy_last_stop", 32'(busy2), 32'd1);
      if (k == 66) chk("t6_busy_idle", 32'(busy2), 32'd0);
      step();
    end
    chk("t6_empty", 32'(empty2), 32'd1);
    chk("t6_overflow", 32'(overflow2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
